// File: rtl/cc_resolve_ctrl_if.sv
// Bundle between the resolve sequencer and its surroundings: frame-end
// handshake, merge/data table RAM ports and the object record stream.
interface cc_resolve_ctrl_if #(
   parameter int WORD_SIZE = 8,
   parameter int OBJ_WIDTH = 128,
   parameter int NUM_OBJS  = 3
);
   localparam int D_WIDTH = NUM_OBJS * OBJ_WIDTH;

   logic                 start;
   logic [WORD_SIZE-1:0] num_labels;
   logic                 own;
   logic                 busy;
   logic                 done;

   logic [WORD_SIZE-1:0] mt_raddr;
   logic [WORD_SIZE-1:0] mt_rdata;
   logic                 mt_wen;
   logic [WORD_SIZE-1:0] mt_waddr;
   logic [WORD_SIZE-1:0] mt_wdata;

   logic [WORD_SIZE-1:0] dt_raddr;
   logic [D_WIDTH-1:0]   dt_rdata;
   logic                 dt_wen;
   logic [WORD_SIZE-1:0] dt_waddr;
   logic [D_WIDTH-1:0]   dt_wdata;

   logic                 obj_valid;
   logic                 obj_ready;
   logic [WORD_SIZE-1:0] obj_label;
   logic [D_WIDTH-1:0]   obj_data;

   modport master (
      input  start, num_labels, mt_rdata, dt_rdata, obj_ready,
      output own, busy, done,
      output mt_raddr, mt_wen, mt_waddr, mt_wdata,
      output dt_raddr, dt_wen, dt_waddr, dt_wdata,
      output obj_valid, obj_label, obj_data
   );

   modport slave (
      output start, num_labels, mt_rdata, dt_rdata, obj_ready,
      input  own, busy, done,
      input  mt_raddr, mt_wen, mt_waddr, mt_wdata,
      input  dt_raddr, dt_wen, dt_waddr, dt_wdata,
      input  obj_valid, obj_label, obj_data
   );
endinterface

// File: rtl/cc_resolve_ctrl.sv
// End-of-frame resolve sequencer for the connected-components labeler:
// flattens the merge table, folds child moments into roots, then streams
// one record per non-empty root.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | RAMs owned by the pixel-rate labeler, waiting for start
// FL_RD  | flatten: read m[i]
// FL_CHK | flatten: root/corrupt -> write m[i]=i, else read m[m[i]]
// FL_WR  | flatten: write m[i] = root of its parent
// AC_RD  | accumulate: read m[i]
// AC_CHK | accumulate: root -> next label, else read D[i]
// AC_RDC | accumulate: capture D[i], read D[R]
// AC_WR  | accumulate: write D[R] = D[R] + D[i] field-wise
// AC_CLR | accumulate: write D[i] = 0
// EM_RD  | emit: read m[i]
// EM_CHK | emit: root -> read D[i], else next label
// EM_DAT | emit: capture record if p != 0
// EM_OUT | emit: hold record until accepted
// FIN    | last cycle of ownership; done pulses on the way to IDLE
module cc_resolve_ctrl #(
   parameter int WORD_SIZE = 8,
   parameter int OBJ_WIDTH = 128,
   parameter int NUM_OBJS  = 3
) (
   input logic               clk,
   input logic               reset,
   cc_resolve_ctrl_if.master bus
);
   localparam int D_WIDTH = NUM_OBJS * OBJ_WIDTH;
   localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

   typedef enum logic [3:0] {
      IDLE, FL_RD, FL_CHK, FL_WR, AC_RD, AC_CHK, AC_RDC, AC_WR, AC_CLR,
      EM_RD, EM_CHK, EM_DAT, EM_OUT, FIN
   } state_t;

   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] i_q, i_d;
   logic [WORD_SIZE-1:0] n_q, n_d;
   logic [WORD_SIZE-1:0] root_q, root_d;
   logic [D_WIDTH-1:0]   child_q, child_d;
   logic [WORD_SIZE-1:0] obj_label_q, obj_label_d;
   logic [D_WIDTH-1:0]   obj_data_q, obj_data_d;
   logic                 done_q;

   logic                 adv;
   logic                 last_lbl;
   logic [D_WIDTH-1:0]   sum;
   logic [WORD_SIZE-1:0] mt_raddr, mt_waddr, mt_wdata;
   logic [WORD_SIZE-1:0] dt_raddr, dt_waddr;
   logic [D_WIDTH-1:0]   dt_wdata;
   logic                 mt_wen, dt_wen, obj_valid;

   assign last_lbl = (i_q == n_q - ONE);

   // Field-wise moment sum; each field wraps on its own with no carry out.
   always_comb begin
      sum = '0;
      for (int f = 0; f < NUM_OBJS; f++) begin
         sum[f*OBJ_WIDTH +: OBJ_WIDTH] = child_q[f*OBJ_WIDTH +: OBJ_WIDTH]
                                       + bus.dt_rdata[f*OBJ_WIDTH +: OBJ_WIDTH];
      end
   end

   // Next-state, RAM strobes and label-loop stepping.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      n_d         = n_q;
      root_d      = root_q;
      child_d     = child_q;
      obj_label_d = obj_label_q;
      obj_data_d  = obj_data_q;
      adv         = 1'b0;
      mt_raddr    = '0;
      mt_wen      = 1'b0;
      mt_waddr    = '0;
      mt_wdata    = '0;
      dt_raddr    = '0;
      dt_wen      = 1'b0;
      dt_waddr    = '0;
      dt_wdata    = '0;
      obj_valid   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               n_d     = bus.num_labels;
               i_d     = ONE;
               state_d = (bus.num_labels <= ONE) ? FIN : FL_RD;
            end
         end
         FL_RD: begin
            mt_raddr = i_q;
            state_d  = FL_CHK;
         end
         FL_CHK: begin
            // A parent above its child can only be corruption; make it a root.
            if (bus.mt_rdata >= i_q) begin
               mt_wen   = 1'b1;
               mt_waddr = i_q;
               mt_wdata = i_q;
               adv      = 1'b1;
            end else begin
               mt_raddr = bus.mt_rdata;
               state_d  = FL_WR;
            end
         end
         FL_WR: begin
            // Parent is below i, so its entry is already flat.
            mt_wen   = 1'b1;
            mt_waddr = i_q;
            mt_wdata = bus.mt_rdata;
            adv      = 1'b1;
         end
         AC_RD: begin
            mt_raddr = i_q;
            state_d  = AC_CHK;
         end
         AC_CHK: begin
            if (bus.mt_rdata == i_q) begin
               adv = 1'b1;
            end else begin
               root_d   = bus.mt_rdata;
               dt_raddr = i_q;
               state_d  = AC_RDC;
            end
         end
         AC_RDC: begin
            child_d  = bus.dt_rdata;
            dt_raddr = root_q;
            state_d  = AC_WR;
         end
         AC_WR: begin
            dt_wen   = 1'b1;
            dt_waddr = root_q;
            dt_wdata = sum;
            state_d  = AC_CLR;
         end
         AC_CLR: begin
            dt_wen   = 1'b1;
            dt_waddr = i_q;
            adv      = 1'b1;
         end
         EM_RD: begin
            mt_raddr = i_q;
            state_d  = EM_CHK;
         end
         EM_CHK: begin
            if (bus.mt_rdata == i_q) begin
               dt_raddr = i_q;
               state_d  = EM_DAT;
            end else begin
               adv = 1'b1;
            end
         end
         EM_DAT: begin
            if (bus.dt_rdata[OBJ_WIDTH-1:0] != '0) begin
               obj_label_d = i_q;
               obj_data_d  = bus.dt_rdata;
               state_d     = EM_OUT;
            end else begin
               adv = 1'b1;
            end
         end
         EM_OUT: begin
            obj_valid = 1'b1;
            if (bus.obj_ready) adv = 1'b1;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Step to the next label, or on the last one rewind i and open the next pass.
      if (adv) begin
         if (last_lbl) begin
            i_d = ONE;
            case (state_q)
               FL_CHK, FL_WR:  state_d = AC_RD;
               AC_CHK, AC_CLR: state_d = EM_RD;
               default:        state_d = FIN;
            endcase
         end else begin
            i_d = i_q + ONE;
            case (state_q)
               FL_CHK, FL_WR:  state_d = FL_RD;
               AC_CHK, AC_CLR: state_d = AC_RD;
               default:        state_d = EM_RD;
            endcase
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         i_q         <= ONE;
         n_q         <= '0;
         root_q      <= '0;
         child_q     <= '0;
         obj_label_q <= '0;
         obj_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         n_q         <= n_d;
         root_q      <= root_d;
         child_q     <= child_d;
         obj_label_q <= obj_label_d;
         obj_data_q  <= obj_data_d;
         done_q      <= (state_q == FIN);
      end
   end

   assign bus.own       = (state_q != IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.mt_raddr  = mt_raddr;
   assign bus.mt_wen    = mt_wen;
   assign bus.mt_waddr  = mt_waddr;
   assign bus.mt_wdata  = mt_wdata;
   assign bus.dt_raddr  = dt_raddr;
   assign bus.dt_wen    = dt_wen;
   assign bus.dt_waddr  = dt_waddr;
   assign bus.dt_wdata  = dt_wdata;
   assign bus.obj_valid = obj_valid;
   assign bus.obj_label = obj_label_q;
   assign bus.obj_data  = obj_data_q;
endmodule

// File: tb/tb_cc_resolve_ctrl.sv
// Bench for the resolve sequencer: behavioural RAMs, a root-following
// reference model and a record scoreboard.
module tb_cc_resolve_ctrl;
   localparam int WS    = 8;
   localparam int OW    = 128;
   localparam int NO    = 3;
   localparam int DW    = NO * OW;
   localparam int DEPTH = 1 << WS;
   localparam int LIMIT = 20000;

   typedef struct {
      logic [WS-1:0] lbl;
      logic [DW-1:0] dat;
   } rec_t;

   logic clk;
   logic reset;

   cc_resolve_ctrl_if #(.WORD_SIZE(WS), .OBJ_WIDTH(OW), .NUM_OBJS(NO)) bus ();

   cc_resolve_ctrl #(.WORD_SIZE(WS), .OBJ_WIDTH(OW), .NUM_OBJS(NO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [WS-1:0] mt_mem [0:DEPTH-1];
   logic [DW-1:0] dt_mem [0:DEPTH-1];
   logic [WS-1:0] m0 [0:DEPTH-1];
   logic [DW-1:0] d0 [0:DEPTH-1];
   logic [WS-1:0] em [0:DEPTH-1];
   logic [DW-1:0] ed [0:DEPTH-1];
   rec_t          exp_q [$];
   rec_t          rec;

   int n_chk = 0;
   int n_err = 0;
   int done_cnt = 0;
   int mt_wen_cnt = 0;
   int dt_wen_cnt = 0;
   int rec_cnt = 0;
   int bad_en_cnt = 0;
   bit            hold_q = 1'b0;
   logic [WS-1:0] hold_lbl;
   logic [DW-1:0] hold_dat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Synchronous-read RAMs with one cycle of read latency.
   always @(posedge clk) begin
      bus.mt_rdata <= mt_mem[bus.mt_raddr];
      bus.dt_rdata <= dt_mem[bus.dt_raddr];
      if (bus.mt_wen) mt_mem[bus.mt_waddr] <= bus.mt_wdata;
      if (bus.dt_wen) dt_mem[bus.dt_waddr] <= bus.dt_wdata;
   end

   // Output monitor: event counters, hold stability and record scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.done) done_cnt++;
         if (bus.mt_wen) mt_wen_cnt++;
         if (bus.dt_wen) dt_wen_cnt++;
         if ((bus.mt_wen || bus.dt_wen || bus.obj_valid) && !bus.own) bad_en_cnt++;
         if (hold_q) begin
            check("hold_valid", DW'(bus.obj_valid), DW'(1'b1));
            check("hold_label", DW'(bus.obj_label), DW'(hold_lbl));
            check("hold_data", bus.obj_data, hold_dat);
         end
         if (bus.obj_valid && bus.obj_ready) begin
            rec_cnt++;
            check("rec_expected", DW'(exp_q.size() != 0), DW'(1'b1));
            if (exp_q.size() != 0) begin
               rec = exp_q.pop_front();
               check("rec_label", DW'(bus.obj_label), DW'(rec.lbl));
               check("rec_data", bus.obj_data, rec.dat);
            end
         end
         hold_q   = bus.obj_valid && !bus.obj_ready;
         hold_lbl = bus.obj_label;
         hold_dat = bus.obj_data;
      end else begin
         hold_q = 1'b0;
      end
   end

   function automatic logic [DW-1:0] mk(input logic [OW-1:0] p, input logic [OW-1:0] x,
                                        input logic [OW-1:0] y);
      return {y, x, p};
   endfunction

   function automatic logic [DW-1:0] add_fields(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      r = '0;
      for (int f = 0; f < NO; f++) r[f*OW +: OW] = a[f*OW +: OW] + b[f*OW +: OW];
      return r;
   endfunction

   // Follow parents downward; an entry not below its own label ends the chain.
   function automatic logic [WS-1:0] root_of(input logic [WS-1:0] k);
      logic [WS-1:0] x;
      x = k;
      for (int s = 0; s < DEPTH; s++) if (m0[x] < x) x = m0[x];
      return x;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < DEPTH; k++) begin
         m0[k] = WS'(k);
         d0[k] = '0;
      end
   endtask

   task automatic load_mem();
      for (int k = 0; k < DEPTH; k++) begin
         mt_mem[k] <= m0[k];
         dt_mem[k] <= d0[k];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic build_expected(input int n);
      rec_t r;
      for (int k = 0; k < DEPTH; k++) begin
         em[k] = m0[k];
         ed[k] = d0[k];
      end
      for (int k = 1; k < n; k++) begin
         em[k] = root_of(WS'(k));
         ed[k] = '0;
      end
      for (int k = 1; k < n; k++) ed[em[k]] = add_fields(ed[em[k]], d0[k]);
      exp_q.delete();
      for (int k = 1; k < n; k++) begin
         if (em[k] == WS'(k) && ed[k][OW-1:0] != '0) begin
            r.lbl = WS'(k);
            r.dat = ed[k];
            exp_q.push_back(r);
         end
      end
   endtask

   task automatic run_frame(input int n, input int stall, input bit poke);
      int  cyc;
      int  stall_left;
      int  done0;
      bit  seen;
      build_expected(n);
      load_mem();
      mt_wen_cnt = 0;
      dt_wen_cnt = 0;
      rec_cnt    = 0;
      bad_en_cnt = 0;
      stall_left = stall;
      bus.obj_ready  = (stall == 0);
      bus.start      = 1'b1;
      bus.num_labels = WS'(n);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("own_hi", DW'(bus.own), DW'(1'b1));
      check("busy_hi", DW'(bus.busy), DW'(1'b1));
      done0 = done_cnt;
      seen  = 1'b0;
      cyc   = 0;
      while (!seen && cyc < LIMIT) begin
         @(posedge clk);
         #1;
         cyc++;
         bus.start = poke && (cyc == 2);
         if (poke && cyc == 2) bus.num_labels = WS'(2);
         if (stall_left > 0 && bus.obj_valid) begin
            stall_left--;
            if (stall_left == 0) bus.obj_ready = 1'b1;
         end
         if (bus.done) seen = 1'b1;
      end
      bus.start     = 1'b0;
      bus.obj_ready = 1'b1;
      check("done_seen", DW'(seen), DW'(1'b1));
      check("own_lo_at_done", DW'(bus.own), DW'(1'b0));
      if (n <= 1) begin
         check("short_done_latency", DW'(cyc <= 3), DW'(1'b1));
         check("short_mt_wen", DW'(mt_wen_cnt), DW'(0));
         check("short_dt_wen", DW'(dt_wen_cnt), DW'(0));
         check("short_records", DW'(rec_cnt), DW'(0));
      end
      @(posedge clk);
      #1;
      check("done_one_cycle", DW'(bus.done), DW'(1'b0));
      check("done_count", DW'(done_cnt - done0), DW'(1));
      check("records_left", DW'(exp_q.size()), DW'(0));
      check("en_without_own", DW'(bad_en_cnt), DW'(0));
      for (int k = 0; k < DEPTH; k++) begin
         check("mt_final", DW'(mt_mem[k]), DW'(em[k]));
         check("dt_final", dt_mem[k], ed[k]);
      end
   endtask

   initial begin
      int  cyc;
      bit  seen;
      int  done0;
      bus.start      = 1'b0;
      bus.num_labels = '0;
      bus.obj_ready  = 1'b1;
      reset          = 1'b1;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_own", DW'(bus.own), DW'(1'b0));
      check("rst_busy", DW'(bus.busy), DW'(1'b0));
      check("rst_done", DW'(bus.done), DW'(1'b0));
      check("rst_obj_valid", DW'(bus.obj_valid), DW'(1'b0));
      check("rst_mt_wen", DW'(bus.mt_wen), DW'(1'b0));
      check("rst_dt_wen", DW'(bus.dt_wen), DW'(1'b0));
      check("rst_obj_label", DW'(bus.obj_label), DW'(0));
      check("rst_obj_data", bus.obj_data, '0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Degenerate frame: nothing to resolve.
      run_frame(1, 0, 1'b0);

      // Single chain folding into label 1.
      clear_model();
      m0[1] = 1; m0[2] = 1; m0[3] = 2; m0[4] = 3;
      d0[1] = mk(2, 10, 5);
      d0[2] = mk(3, 20, 5);
      d0[3] = mk(1, 30, 5);
      d0[4] = mk(4, 40, 5);
      run_frame(5, 0, 1'b0);

      // Two roots with the first record back-pressured.
      clear_model();
      m0[3] = 1;
      d0[1] = mk(1, 2, 3);
      d0[2] = mk(4, 5, 6);
      d0[3] = mk(7, 8, 9);
      run_frame(4, 5, 1'b0);

      // Empty root 3 is skipped.
      clear_model();
      m0[4] = 1;
      d0[1] = mk(5, 6, 7);
      d0[2] = mk(1, 1, 1);
      d0[4] = mk(2, 3, 4);
      run_frame(5, 0, 1'b0);

      // Stray start during the flatten pass.
      clear_model();
      m0[2] = 1; m0[3] = 2; m0[4] = 3;
      d0[1] = mk(2, 10, 5);
      d0[3] = mk(1, 30, 5);
      run_frame(5, 0, 1'b1);

      // Reset during the accumulate pass, then a clean rerun.
      clear_model();
      m0[3] = 1;
      d0[1] = mk(1, 2, 3);
      d0[3] = mk(7, 8, 9);
      load_mem();
      bus.start      = 1'b1;
      bus.num_labels = WS'(4);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < LIMIT) begin
         if (bus.dt_wen) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      check("acc_pass_reached", DW'(seen), DW'(1'b1));
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("own_after_reset", DW'(bus.own), DW'(1'b0));
      check("valid_after_reset", DW'(bus.obj_valid), DW'(1'b0));
      reset = 1'b0;
      done0 = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      check("no_done_after_reset", DW'(done_cnt - done0), DW'(0));
      run_frame(4, 0, 1'b0);

      // Corrupt parent pointer above its child.
      clear_model();
      m0[2] = 5; m0[3] = 1;
      d0[1] = mk(1, 1, 1);
      d0[2] = mk(2, 2, 2);
      d0[3] = mk(3, 3, 3);
      run_frame(4, 0, 1'b0);

      // Full-size frame with random forest and full-width moments.
      clear_model();
      for (int k = 1; k < DEPTH - 1; k++) begin
         m0[k] = WS'($urandom_range(1, k));
         d0[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         if (k % 11 == 0) d0[k] = '0;
      end
      m0[1] = 1;
      run_frame(DEPTH - 1, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/cc_resolve_ctrl.md
Name: cc_resolve_ctrl

Overview:
- End-of-frame sequencer for the connected-components labeler.
- After the last pixel of a frame, it takes ownership of the merge table and data table RAMs and runs three passes:
  1. Flattens the merge table so that every label points directly at its root.
  2. Folds each non-root label's accumulated moments (p, x·p, y·p) into its root's entry.
  3. Streams one object record per non-empty root over a valid/ready interface to the centroid/output stage.
- Ownership returns to the pixel-rate labeler when done.

Parameters:
WORD_SIZE, 8, label width; merge table depth is 2^WORD_SIZE.
OBJ_WIDTH, 128, width of one moment field.
NUM_OBJS, 3, fields per data table entry; D_WIDTH = NUM_OBJS*OBJ_WIDTH, layout {y_acc, x_acc, p_acc} with p in the LSB field.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle pulse at frame end; sampled only in IDLE.
num_labels  in  WORD_SIZE  next-free label count (label 0 reserved); captured on accepted start.
own  out  1  high while not IDLE; external mux routes both RAM port sets to this block.
busy  out  1  same as own.
done  out  1  one-cycle pulse on the return to IDLE after a run.
mt_raddr  out  WORD_SIZE  merge table read address; data returned 1 cycle later.
mt_rdata  in  WORD_SIZE  merge table read data.
mt_wen  out  1  merge table write enable.
mt_waddr  out  WORD_SIZE  merge table write address.
mt_wdata  out  WORD_SIZE  merge table write data.
dt_raddr  out  WORD_SIZE  data table read address; data returned 1 cycle later.
dt_rdata  in  D_WIDTH  data table read data.
dt_wen  out  1  data table write enable.
dt_waddr  out  WORD_SIZE  data table write address.
dt_wdata  out  D_WIDTH  data table write data.
obj_valid  out  1  object record valid.
obj_ready  in  1  downstream accepts the record.
obj_label  out  WORD_SIZE  root label of the record.
obj_data  out  D_WIDTH  merged {y_acc, x_acc, p_acc} of the record.

Behaviour:
- Reset values: all outputs 0, state IDLE, label counter i = 1. RAM contents are not touched.
- Reset mid-run: IDLE on the next cycle, no done pulse, any partial writes are left as-is.
- Invariant assumed: merge table entry m[i] <= i.

IDLE:
- On start, latch N = num_labels and set i = 1.
- If N <= 1, go to FIN (no RAM access, no records); otherwise go to FL_RD.
- start outside IDLE is ignored.

Flatten pass, i ascending 1..N-1:
- FL_RD: read m[i].
- FL_CHK: r = mt_rdata.
  - If r == i or r > i (corrupt), write m[i] = i and advance.
  - Otherwise read m[r] and go to FL_WR.
- FL_WR: write m[i] = mt_rdata (root of r, already flat because r < i), then advance.
- Cost: 2 cycles per root, 3 per non-root.
- After i = N-1, set i = 1 and go to AC_RD.

Accumulate pass, i ascending 1..N-1:
- AC_RD: read m[i] (now root R).
- If R == i, advance.
- Otherwise:
  - read D[i], then read D[R];
  - write D[R] = field-wise sum, each field mod 2^OBJ_WIDTH with no carry between fields;
  - next cycle write D[i] = 0.
- Reads and writes are strictly sequential; there is never a same-address read and write in one cycle.

Emit pass, i ascending 1..N-1:
- Read m[i].
- If root, read D[i].
  - If its p field != 0, present obj_label = i and obj_data = D[i] with obj_valid = 1.
- obj_valid, obj_label and obj_data are held stable until the cycle where obj_valid && obj_ready; advance on the next cycle.
- Roots with p == 0 are skipped silently.

FIN:
- Drop own, pulse done, go to IDLE.

General rules:
- The label counter never wraps: the loop exits when i == N-1 completes.
- N = 2^WORD_SIZE - 1 (i.e. 255) is legal.
- mt_wen and dt_wen are never both asserted to the same RAM twice in one cycle.
- No RAM enable is asserted while own = 0.

Test Plan:
- num_labels = 1, start -> own high, done pulses within 3 cycles, zero mt_wen/dt_wen/obj_valid.
- Chain m = {0,1,1,2,3}, N = 5, p of labels 1..4 = 2,3,1,4 with x·p = 10,20,30,40 and y·p = 5,5,5,5 -> m[1..4] all read back 1; exactly one record, label 1, p = 10, x = 100, y = 20; D[2..4] zeroed; done follows.
- Two roots (m = {0,1,2,1}, N = 4), obj_ready held low for 5 cycles -> record for label 1 held stable for all 5 cycles, then label 2 emitted; label order 1,2.
- Root label 3 with p = 0 and no children -> no record for 3; other roots emitted normally.
- start pulsed during the flatten pass -> ignored, single done; reset asserted during the accumulate pass -> own = 0 next cycle, no done, a new start then completes a full run.
- Corrupt entry m[2] = 5, N = 4 -> m[2] rewritten to 2, treated as root.
